// File: rtl/dmem_dump_reader.sv
// Debug-side data-memory dumper: reads words 0..N_WORDS-1 through a read port and
// streams each word MSB-first as four bytes over a start/done UART handshake.
module dmem_dump_reader #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 8,
  parameter int unsigned N_WORDS = 256
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_rd_en,
  output logic [NB_ADDR-1:0] o_rd_addr,
  input  logic [NB_DATA-1:0] i_rd_data,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned NB_BYTE = 8;
  localparam int unsigned NB_BCNT = 2;
  localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_WORDS - 1);
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(3);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    WAIT_TX,
    DONE
  } state_t;

  state_t             state;
  logic [NB_ADDR-1:0] word_idx;
  logic [NB_BCNT-1:0] byte_cnt;
  logic [NB_DATA-1:0] shift;

  // Outputs are loaded on the transition into the state that presents them,
  // so they line up with the state register without extra decode delay.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      word_idx   <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      o_rd_en    <= 1'b0;
      o_rd_addr  <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_rd_en    <= 1'b0;
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= READ;
            o_rd_en   <= 1'b1;
            o_rd_addr <= word_idx;
            o_busy    <= 1'b1;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          shift      <= i_rd_data;
          byte_cnt   <= '0;
          o_tx_data  <= i_rd_data[NB_DATA-1 -: NB_BYTE];
          o_tx_start <= 1'b1;
          state      <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (i_tx_done) begin
            if (byte_cnt != LAST_BYTE) begin
              shift      <= {shift[NB_DATA-NB_BYTE-1:0], NB_BYTE'(0)};
              byte_cnt   <= byte_cnt + NB_BCNT'(1);
              o_tx_data  <= shift[NB_DATA-NB_BYTE-1 -: NB_BYTE];
              o_tx_start <= 1'b1;
              state      <= SEND;
            end else if (word_idx == LAST_IDX) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              word_idx  <= word_idx + NB_ADDR'(1);
              o_rd_en   <= 1'b1;
              o_rd_addr <= word_idx + NB_ADDR'(1);
              state     <= READ;
            end
          end
        end
        DONE: begin
          word_idx <= '0;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Scoreboard bench for dmem_dump_reader: a 2-word instance for handshake/reset cases
// and a 256-word instance for the full-range dump.
module tb_dmem_dump_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- 2-word instance ----------------
  logic        start2, rd_en2, tx_start2, tx_done2, busy2, done2, inj2;
  logic [7:0]  rd_addr2, tx_data2;
  logic [31:0] rd_data2;
  logic [31:0] mem2 [256];
  logic [2:0]  dl2;

  dmem_dump_reader #(.NB_DATA(32), .NB_ADDR(8), .N_WORDS(2)) dut2 (
    .clk(clk), .i_reset(rst_n), .i_start(start2),
    .o_rd_en(rd_en2), .o_rd_addr(rd_addr2), .i_rd_data(rd_data2),
    .o_tx_data(tx_data2), .o_tx_start(tx_start2), .i_tx_done(tx_done2),
    .o_busy(busy2), .o_done(done2)
  );

  always @(posedge clk) if (rd_en2) rd_data2 <= mem2[rd_addr2];
  always @(posedge clk) dl2 <= !rst_n ? 3'b000 : {dl2[1:0], tx_start2};
  assign tx_done2 = dl2[2] | inj2;

  // ---------------- 256-word instance ----------------
  logic        startb, rd_enb, tx_startb, tx_doneb, busyb, doneb;
  logic [7:0]  rd_addrb, tx_datab;
  logic [31:0] rd_datab;
  logic [2:0]  dlb;

  dmem_dump_reader #(.NB_DATA(32), .NB_ADDR(8), .N_WORDS(256)) dutb (
    .clk(clk), .i_reset(rst_n), .i_start(startb),
    .o_rd_en(rd_enb), .o_rd_addr(rd_addrb), .i_rd_data(rd_datab),
    .o_tx_data(tx_datab), .o_tx_start(tx_startb), .i_tx_done(tx_doneb),
    .o_busy(busyb), .o_done(doneb)
  );

  always @(posedge clk) if (rd_enb) rd_datab <= 32'(rd_addrb);
  always @(posedge clk) dlb <= !rst_n ? 3'b000 : {dlb[1:0], tx_startb};
  assign tx_doneb = dlb[2];

  // ---------------- scoreboards / monitors ----------------
  logic [7:0] q2[$];
  logic [7:0] qb[$];
  int done_cnt2 = 0;
  int done_cntb = 0;
  int rd_cntb = 0;

  always @(negedge clk) begin
    if (tx_start2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL byte2_extra: got byte %02h with none expected", tx_data2);
      end else begin
        check("byte2", 32'(tx_data2), 32'(q2.pop_front()));
      end
    end
    if (done2) done_cnt2++;
  end

  always @(negedge clk) begin
    if (tx_startb) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL byteb_extra: got byte %02h with none expected", tx_datab);
      end else begin
        check("byteb", 32'(tx_datab), 32'(qb.pop_front()));
      end
    end
    if (rd_enb) begin
      check("rd_addr_b", 32'(rd_addrb), 32'(rd_cntb));
      rd_cntb++;
    end
    if (doneb) done_cntb++;
  end

  task automatic push_word2(input logic [31:0] w);
    q2.push_back(w[31:24]); q2.push_back(w[23:16]);
    q2.push_back(w[15:8]);  q2.push_back(w[7:0]);
  endtask

  task automatic push_dump2();
    push_word2(32'hDEADBEEF);
    push_word2(32'h01234567);
  endtask

  task automatic start_dut2();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  // Waits for dut2 to go idle, then checks done count and scoreboard drain.
  task automatic finish_dump2(input string nm, input int exp_done);
    int n = 0;
    while (busy2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_timeout"}, 32'(busy2), 32'd0);
    check({nm, "_done_cnt"}, 32'(done_cnt2), 32'(exp_done));
    check({nm, "_queue_left"}, 32'(q2.size()), 32'd0);
  endtask

  task automatic check_zero2(input string nm);
    check({nm, "_rd_en"}, 32'(rd_en2), 32'd0);
    check({nm, "_rd_addr"}, 32'(rd_addr2), 32'd0);
    check({nm, "_tx_start"}, 32'(tx_start2), 32'd0);
    check({nm, "_tx_data"}, 32'(tx_data2), 32'd0);
    check({nm, "_busy"}, 32'(busy2), 32'd0);
    check({nm, "_done"}, 32'(done2), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int n;
    for (int i = 0; i < 256; i++) mem2[i] = 32'hBAD00000 + 32'(i);
    mem2[0] = 32'hDEADBEEF;
    mem2[1] = 32'h01234567;
    rst_n = 1'b0; start2 = 1'b0; startb = 1'b0; inj2 = 1'b0;
    repeat (3) @(negedge clk);
    check_zero2("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // tx_done in IDLE must not start anything
    inj2 = 1'b1;
    @(negedge clk);
    inj2 = 1'b0;
    check("idle_txdone_busy", 32'(busy2), 32'd0);
    check("idle_txdone_txstart", 32'(tx_start2), 32'd0);
    @(negedge clk);
    check("idle_txdone_rd_en", 32'(rd_en2), 32'd0);

    // Basic dump with cycle-accurate start of transfer
    push_dump2();
    start_dut2();
    check("c1_rd_en", 32'(rd_en2), 32'd1);
    check("c1_rd_addr", 32'(rd_addr2), 32'd0);
    check("c1_busy", 32'(busy2), 32'd1);
    @(negedge clk);
    check("c2_rd_en", 32'(rd_en2), 32'd0);
    check("c2_tx_start", 32'(tx_start2), 32'd0);
    @(negedge clk);
    check("c3_tx_start", 32'(tx_start2), 32'd1);
    check("c3_tx_data", 32'(tx_data2), 32'hDE);
    finish_dump2("dump1", 1);
    @(negedge clk);
    check("dump1_busy_after", 32'(busy2), 32'd0);

    // Restart request during byte 2 and tx_done in SEND of byte 3 both ignored
    push_dump2();
    start_dut2();
    cnt = 0; n = 0;
    while (busy2 && n < 500) begin
      @(negedge clk);
      n++;
      if (tx_start2) begin
        cnt++;
        if (cnt == 2) start2 = 1'b1;
        if (cnt == 3) inj2 = 1'b1;
      end else begin
        start2 = 1'b0;
        inj2 = 1'b0;
      end
    end
    start2 = 1'b0; inj2 = 1'b0;
    finish_dump2("dump2", 2);
    repeat (4) @(negedge clk);
    check("dump2_no_requeue", 32'(busy2), 32'd0);
    check("dump2_no_extra_done", 32'(done_cnt2), 32'd2);

    // Reset while waiting on byte 5, then a clean restart
    push_dump2();
    start_dut2();
    cnt = 0; n = 0;
    while (cnt < 5 && n < 500) begin
      @(negedge clk);
      n++;
      if (tx_start2) cnt++;
    end
    check("dump3_reached_byte5", 32'(cnt), 32'd5);
    @(negedge clk);
    check("dump3_wait_tx_busy", 32'(busy2), 32'd1);
    check("dump3_wait_tx_start", 32'(tx_start2), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero2("midreset");
    rst_n = 1'b1;
    q2.delete();
    @(negedge clk);
    check("midreset_done_cnt", 32'(done_cnt2), 32'd2);
    push_dump2();
    start_dut2();
    check("restart_rd_en", 32'(rd_en2), 32'd1);
    check("restart_rd_addr", 32'(rd_addr2), 32'd0);
    finish_dump2("dump4", 3);

    // Full 256-word dump, mem[i] = i
    for (int i = 0; i < 256; i++) begin
      qb.push_back(8'h00); qb.push_back(8'h00); qb.push_back(8'h00);
      qb.push_back(8'(i));
    end
    startb = 1'b1;
    @(negedge clk);
    startb = 1'b0;
    n = 0;
    while (busyb && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("full_timeout", 32'(busyb), 32'd0);
    check("full_done_cnt", 32'(done_cntb), 32'd1);
    check("full_last_addr", 32'(rd_addrb), 32'hFF);
    check("full_read_cnt", 32'(rd_cntb), 32'd256);
    check("full_queue_left", 32'(qb.size()), 32'd0);
    repeat (4) @(negedge clk);
    check("full_no_wrap_read", 32'(rd_cntb), 32'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
